// File: rtl/irq_pend_pkg.sv
// -----------------------------------------------------------------------------
// irq_pend_pkg
// Shared definitions for the interrupt pending/arbitration block:
//   - FSM state encoding (IDLE = 0, REQ = 1)
//   - default synchronizer depth and REQ timeout
//   - timeout counter width and type
// -----------------------------------------------------------------------------
package irq_pend_pkg;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int TIMEOUT_DEF     = 16;
   localparam int CNT_W           = 8;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_REQ  = 1'b1;

   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/irq_pend_sync.sv
// -----------------------------------------------------------------------------
// irq_sync
// One request line: SYNC_STAGES-deep synchronizer followed by a rising-edge
// detector.
// Ports:
//   clk    - clock
//   rst    - synchronous active-high reset
//   i_line - raw asynchronous request line
//   o_rise - one-cycle pulse when the synchronized line goes 0 -> 1
// -----------------------------------------------------------------------------
module irq_sync
   import irq_pend_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_line,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   // Tracks which flops hold a real post-reset sample. The reset value 0 of
   // the pipeline is not a genuine "low", so a line already high when reset
   // is released must not be taken as a fresh rising edge.
   logic [SYNC_STAGES:0]   r_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
         r_vld  <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
         r_prev <= r_sync[SYNC_STAGES-1];
         r_vld  <= {r_vld[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign o_rise = r_vld[SYNC_STAGES] & r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/irq_pend.sv
// -----------------------------------------------------------------------------
// irq_pend
// Captures rising edges on 8 asynchronous request lines into a pending
// vector, presents the masked vector to an external priority encoder and
// services the encoder's choice with a request/acknowledge handshake that
// gives up after TIMEOUT cycles.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   irq_in[7:0]  - raw request lines (bit 7 highest priority)
//   mask[7:0]    - 1 = line takes part in arbitration
//   pend_out     - pending & mask, to encoder data input
//   pend_en      - encoder enable (high in IDLE)
//   code_in      - encoder code
//   none_in      - encoder "nothing valid" flag
//   irq_req      - service request, high while in REQ
//   irq_code     - line being serviced, stable while irq_req = 1
//   irq_ack      - consumer acknowledge (pulse or level)
//   irq_timeout  - one-cycle pulse when a REQ period expires unacknowledged
// -----------------------------------------------------------------------------
module irq_pend
   import irq_pend_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] irq_in,
   input  logic [7:0] mask,
   output logic [7:0] pend_out,
   output logic       pend_en,
   input  logic [2:0] code_in,
   input  logic       none_in,
   output logic       irq_req,
   output logic [2:0] irq_code,
   input  logic       irq_ack,
   output logic       irq_timeout
);

   logic [7:0] w_rise;
   logic [7:0] w_clr;
   logic       w_ack;
   logic       w_expire;

   logic [0:0] r_state;
   logic [7:0] r_pending;
   cnt_t       r_cnt;
   logic [2:0] r_code;
   logic       r_timeout;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_sync
         irq_sync #(
            .SYNC_STAGES (SYNC_STAGES)
         ) u_sync (
            .clk    (clk),
            .rst    (rst),
            .i_line (irq_in[gi]),
            .o_rise (w_rise[gi])
         );
      end
   endgenerate

   // Ack only counts in REQ; it retires the latched line whatever the mask is now.
   assign w_ack    = (r_state == ST_REQ) & irq_ack;
   // Ack has priority over expiry.
   assign w_expire = (r_state == ST_REQ) & ~irq_ack & (r_cnt == cnt_t'(TIMEOUT - 1));

   always_comb begin
      w_clr = '0;
      if (w_ack) begin
         w_clr[r_code] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_pending <= '0;
         r_cnt     <= '0;
         r_code    <= '0;
         r_timeout <= 1'b0;
      end else begin
         // A new edge on the line being retired wins over the clear.
         r_pending <= (r_pending & ~w_clr) | w_rise;
         r_timeout <= w_expire;
         case (r_state)
            ST_IDLE: begin
               if (!none_in) begin
                  r_code  <= code_in;
                  r_cnt   <= '0;
                  r_state <= ST_REQ;
               end
            end
            default: begin
               if (w_ack || w_expire) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + cnt_t'(1);
               end
            end
         endcase
      end
   end

   assign pend_out    = r_pending & mask;
   assign pend_en     = (r_state == ST_IDLE);
   assign irq_req     = (r_state == ST_REQ);
   assign irq_code    = r_code;
   assign irq_timeout = r_timeout;

endmodule
